// File: rtl/cpucfg_exu_pkg.sv
// Shared back-end definitions for the CPUCFG execution unit and the issue queue
// that feeds it: FSM state encoding, config-space size and the issued op bundle.
package cpucfg_exu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } cpucfg_state_e;

    localparam int CPUCFG_WORDS  = 32;
    localparam int CPUCFG_ROB_W  = 6;
    localparam int CPUCFG_PREG_W = 6;

    typedef struct packed {
        logic [31:0]              rj;
        logic [CPUCFG_ROB_W-1:0]  rob_idx;
        logic [CPUCFG_PREG_W-1:0] prd;
    } cpucfg_op_t;

endpackage

// File: rtl/cpucfg_exu.sv
// CPUCFG execution unit: latches one issued op, reads the external config lookup
// and holds the result for writeback. Define CPUCFG_B2B_EN to accept a new op in DONE.
module cpucfg_exu
    import cpucfg_exu_pkg::*;
#(
    parameter int ROB_W     = CPUCFG_ROB_W,
    parameter int PREG_W    = CPUCFG_PREG_W,
    parameter int CFG_WORDS = CPUCFG_WORDS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_rj_value,
    input  logic [ROB_W-1:0]  in_rob_idx,
    input  logic [PREG_W-1:0] in_prd,
    output logic [31:0]       cpuconf_id,
    input  logic [31:0]       cpuconf_value,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [ROB_W-1:0]  wb_rob_idx,
    output logic [PREG_W-1:0] wb_prd
);

    cpucfg_state_e     state_q, state_d;
    logic [31:0]       rj_q, rj_d;
    logic [31:0]       data_q, data_d;
    logic [ROB_W-1:0]  rob_idx_q, rob_idx_d;
    logic [PREG_W-1:0] prd_q, prd_d;
    logic              load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rj_q      <= '0;
            data_q    <= '0;
            rob_idx_q <= '0;
            prd_q     <= '0;
        end else begin
            state_q   <= state_d;
            rj_q      <= rj_d;
            data_q    <= data_d;
            rob_idx_q <= rob_idx_d;
            prd_q     <= prd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // Words beyond the implemented range read as zero regardless of the table
                data_d  = (rj_q < 32'(CFG_WORDS)) ? cpuconf_value : 32'h0;
                state_d = DONE;
            end
            DONE: begin
                if (wb_ready) begin
`ifdef CPUCFG_B2B_EN
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = LOOKUP;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            load    = 1'b0;
            data_d  = data_q;
        end
        rj_d      = load ? in_rj_value : rj_q;
        rob_idx_d = load ? in_rob_idx  : rob_idx_q;
        prd_d     = load ? in_prd      : prd_q;
    end

    always_comb begin
        in_ready = 1'b0;
        wb_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            DONE: begin
                wb_valid = 1'b1;
`ifdef CPUCFG_B2B_EN
                in_ready = wb_ready && !flush;
`endif
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign cpuconf_id = rj_q;
    assign wb_data    = data_q;
    assign wb_rob_idx = rob_idx_q;
    assign wb_prd     = prd_q;

endmodule

// File: tb/tb_cpucfg_exu.sv
// Directed, table-driven bench for cpucfg_exu with a behavioural config lookup
// standing in for the sibling table instance.
module tb_cpucfg_exu;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rj_value;
    logic [5:0]  in_rob_idx;
    logic [5:0]  in_prd;
    logic [31:0] cpuconf_id;
    logic [31:0] cpuconf_value;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [5:0]  wb_rob_idx;
    logic [5:0]  wb_prd;

    int testsRun = 0;
    int testsFailed = 0;

    cpucfg_exu dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rj_value  (in_rj_value),
        .in_rob_idx   (in_rob_idx),
        .in_prd       (in_prd),
        .cpuconf_id   (cpuconf_id),
        .cpuconf_value(cpuconf_value),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_rob_idx   (wb_rob_idx),
        .wb_prd       (wb_prd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in config table; out-of-range ids return junk so the unit's zeroing is visible
    always_comb begin
        case (cpuconf_id)
            32'd1:   cpuconf_value = 32'h0001F1F4;
            32'd16:  cpuconf_value = 32'h00000005;
            32'd17:  cpuconf_value = 32'h04080001;
            32'd18:  cpuconf_value = 32'h04080001;
            default: cpuconf_value = (cpuconf_id >= 32'd32) ? 32'hDEADBEEF : 32'h0;
        endcase
    end

    typedef struct {
        logic [31:0] rj;
        logic [5:0]  rob;
        logic [5:0]  prd;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One op with wb_ready high; entered just after a clock edge with the unit idle
    task automatic applyStimulus(input vec_t v);
        logic doneRdy;
`ifdef CPUCFG_B2B_EN
        doneRdy = 1'b1;
`else
        doneRdy = 1'b0;
`endif
        in_valid    = 1'b1;
        in_rj_value = v.rj;
        in_rob_idx  = v.rob;
        in_prd      = v.prd;
        wb_ready    = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        nextCycle();
        in_valid    = 1'b0;
        in_rj_value = 32'hA5A5A5A5;
        in_rob_idx  = 6'h3F;
        in_prd      = 6'h3F;
        @(negedge clk);
        checkOutput("lookup_in_ready", 32'(in_ready), 32'd0);
        checkOutput("lookup_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("lookup_cpuconf_id", cpuconf_id, v.rj);
        nextCycle();
        @(negedge clk);
        checkOutput("done_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("done_wb_data", wb_data, v.expData);
        checkOutput("done_wb_rob_idx", 32'(wb_rob_idx), 32'(v.rob));
        checkOutput("done_wb_prd", 32'(wb_prd), 32'(v.prd));
        checkOutput("done_in_ready", 32'(in_ready), 32'(doneRdy));
        nextCycle();
        @(negedge clk);
        checkOutput("after_wb_valid", 32'(wb_valid), 32'd0);
        nextCycle();
    endtask

    initial begin
        logic [31:0] streamRj[3];
        logic [31:0] streamExp[3];
        int          resCycle[3];
        int          nIssued;
        int          nRes;
        int          expGap;
        logic        accepted;

        vecs[0] = '{rj: 32'd1,          rob: 6'd5,  prd: 6'd9,  expData: 32'h0001F1F4};
        vecs[1] = '{rj: 32'd17,         rob: 6'd12, prd: 6'd33, expData: 32'h04080001};
        vecs[2] = '{rj: 32'd16,         rob: 6'd63, prd: 6'd1,  expData: 32'h00000005};
        vecs[3] = '{rj: 32'd3,          rob: 6'd7,  prd: 6'd40, expData: 32'h0};
        vecs[4] = '{rj: 32'd32,         rob: 6'd2,  prd: 6'd62, expData: 32'h0};
        vecs[5] = '{rj: 32'hFFFFFFFF,   rob: 6'd42, prd: 6'd21, expData: 32'h0};
        vecs[6] = '{rj: 32'd18,         rob: 6'd0,  prd: 6'd0,  expData: 32'h04080001};

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        in_rj_value = '0; in_rob_idx = '0; in_prd = '0;
        #12;
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_wb_rob_idx", 32'(wb_rob_idx), 32'd0);
        checkOutput("rst_wb_prd", 32'(wb_prd), 32'd0);
        checkOutput("rst_cpuconf_id", cpuconf_id, 32'd0);
        rstn = 1'b1;
        nextCycle();
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Backpressure: result must sit unchanged while the arbiter stalls
        in_valid = 1'b1; in_rj_value = 32'd18; in_rob_idx = 6'd11; in_prd = 6'd22; wb_ready = 1'b0;
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_wb_valid", 32'(wb_valid), 32'd1);
            checkOutput("bp_wb_data", wb_data, 32'h04080001);
            checkOutput("bp_wb_rob_idx", 32'(wb_rob_idx), 32'd11);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            nextCycle();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_wb_valid", 32'(wb_valid), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("bp_done_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("bp_done_in_ready", 32'(in_ready), 32'd1);
        nextCycle();

        // Flush during LOOKUP, then in_valid together with flush while idle
        in_valid = 1'b1; in_rj_value = 32'd1; in_rob_idx = 6'd3; in_prd = 6'd4;
        nextCycle();
        in_valid = 1'b0; flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; flush = 1'b1; in_rj_value = 32'd17;
        nextCycle();
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("flush_idle_in_ready", 32'(in_ready), 32'd1);
            checkOutput("flush_idle_wb_valid", 32'(wb_valid), 32'd0);
            nextCycle();
        end

        // Asynchronous reset while holding a result in DONE
        in_valid = 1'b1; in_rj_value = 32'd17; in_rob_idx = 6'd9; in_prd = 6'd8; wb_ready = 1'b0;
        nextCycle();
        in_valid = 1'b0;
        nextCycle();
        #2;
        checkOutput("pre_arst_wb_valid", 32'(wb_valid), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("arst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("arst_wb_data", wb_data, 32'd0);
        checkOutput("arst_wb_rob_idx", 32'(wb_rob_idx), 32'd0);
        checkOutput("arst_wb_prd", 32'(wb_prd), 32'd0);
        checkOutput("arst_cpuconf_id", cpuconf_id, 32'd0);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        nextCycle();
        applyStimulus(vecs[0]);

        // Streamed ops: ordering and result spacing
        streamRj[0] = 32'd1;  streamExp[0] = 32'h0001F1F4;
        streamRj[1] = 32'd17; streamExp[1] = 32'h04080001;
        streamRj[2] = 32'd18; streamExp[2] = 32'h04080001;
`ifdef CPUCFG_B2B_EN
        expGap = 2;
`else
        expGap = 3;
`endif
        nIssued = 0; nRes = 0; wb_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && nRes < 3; cyc++) begin
            in_valid    = (nIssued < 3);
            in_rj_value = (nIssued < 3) ? streamRj[nIssued] : 32'd0;
            in_rob_idx  = 6'(nIssued + 20);
            in_prd      = 6'(nIssued + 30);
            @(negedge clk);
            accepted = in_valid && in_ready;
            if (wb_valid) begin
                checkOutput("stream_wb_data", wb_data, streamExp[nRes]);
                checkOutput("stream_wb_rob_idx", 32'(wb_rob_idx), 32'(nRes + 20));
                resCycle[nRes] = cyc;
                nRes++;
            end
            if (accepted) nIssued++;
            nextCycle();
        end
        in_valid = 1'b0;
        checkOutput("stream_result_count", 32'(nRes), 32'd3);
        if (nRes == 3) begin
            checkOutput("stream_gap_0_1", 32'(resCycle[1] - resCycle[0]), 32'(expGap));
            checkOutput("stream_gap_1_2", 32'(resCycle[2] - resCycle[1]), 32'(expGap));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cpucfg_exu.md
Name: cpucfg_exu

Overview:
- Back-end execution unit for the LoongArch CPUCFG instruction.
- Accepts one issued CPUCFG micro-op and drives the config word index to the combinational config lookup table.
- Registers the returned value and presents it to the writeback/commit path with a valid/ready handshake.
- Sits between the issue queue and the CDB/writeback arbiter; it is the sole consumer of the config lookup.

Parameters:
- ROB_W, 6, ROB index width.
- PREG_W, 6, physical destination register index width.
- CFG_WORDS, 32, number of implemented config words; indices >= CFG_WORDS read as zero.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (branch mispredict/exception); kills any in-flight op
- in_valid  in  1  issue offers a CPUCFG op
- in_ready  out  1  unit can accept this cycle
- in_rj_value  in  32  source operand: config word index
- in_rob_idx  in  ROB_W  ROB tag of the op
- in_prd  in  PREG_W  physical destination register
- cpuconf_id  out  32  index driven to the config lookup
- cpuconf_value  in  32  combinational lookup result for cpuconf_id
- wb_valid  out  1  result available
- wb_ready  in  1  writeback arbiter accepts the result
- wb_data  out  32  config word result
- wb_rob_idx  out  ROB_W  tag of the result
- wb_prd  out  PREG_W  destination of the result

Behaviour:
- Reset (asynchronous, rstn low):
  - state=IDLE; all registers cleared.
  - in_ready=1 once out of reset.
  - wb_valid=0, wb_data=0, wb_rob_idx=0, wb_prd=0, cpuconf_id=0.
- FSM states: IDLE, LOOKUP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && !flush: latch rj, rob_idx and prd, then go to LOOKUP.
- LOOKUP:
  - in_ready=0; cpuconf_id drives the latched rj.
  - At the clock edge, wb_data captures cpuconf_value, or 0 if latched rj >= CFG_WORDS (any of bits [31:5] set for the default). Go to DONE.
- DONE:
  - wb_valid=1; wb_data, wb_rob_idx and wb_prd stay stable until the handshake.
  - On wb_valid && wb_ready: go to IDLE. Back-to-back behaviour is covered under Optional Feature.
- cpuconf_id equals the latched rj in every state; it is 0 only after reset.
- Latency: accept at edge T, wb_valid high from T+2. Baseline throughput is one op per 3 cycles with no stall.
- Backpressure: wb_ready low holds DONE indefinitely; outputs must not change while held.
- Flush:
  - Has priority over every other event. From any state, the next state is IDLE and wb_valid is 0 next cycle.
  - A same-cycle in_valid is not accepted.
  - A same-cycle wb_valid && wb_ready handshake still completes; the arbiter owns discarding it.
- No X propagation: registers hold their value when not loading.

Optional Feature:
- Macro CPUCFG_B2B_EN.
- Defined:
  - In DONE, in_ready = wb_ready && !flush.
  - If wb_valid && wb_ready && in_valid in the same cycle, the new op is latched and the next state is LOOKUP, skipping IDLE.
  - Throughput becomes one op per 2 cycles.
- Undefined:
  - in_ready=0 in DONE; DONE always returns to IDLE.
- Both builds must give identical results for an identical op stream; only timing differs.

Decomposition:
- Shared back-end package holds:
  - typedef cpucfg_state_e {IDLE, LOOKUP, DONE};
  - constant CPUCFG_WORDS = 32;
  - typedef for the op bundle {rj, rob_idx, prd}, reused by the issue queue.
- No sub-module is required. The config lookup stays a separate sibling instance at the parent level and is not instantiated inside this unit.

Test Plan:
- Basic read: rj=1, rob_idx=5, prd=9, wb_ready=1. Expect:
  - wb_valid at T+2 with wb_data=32'h0001F1F4, wb_rob_idx=5, wb_prd=9.
  - in_ready low at T+1 and T+2.
- Range and zero words: rj=17 -> 32'h04080001; rj=16 -> 32'h5; rj=3 -> 0; rj=32 and rj=32'hFFFFFFFF -> 0.
- Backpressure: rj=18 with wb_ready=0 for 5 cycles. Expect:
  - wb_valid held with wb_data=32'h04080001 stable throughout.
  - in_ready=0 throughout.
  - Completes on the first wb_ready=1 cycle.
- Flush: assert flush in the LOOKUP cycle. Expect:
  - wb_valid never asserts; the unit is back in IDLE with in_ready=1 the next cycle.
  - in_valid presented together with flush in IDLE is not accepted.
- Async reset mid-op: drop rstn during DONE (between clock edges). Expect wb_valid=0 and all outputs 0 immediately; after release, rj=1 completes normally.
- Back-to-back: stream rj=1,17,18 with wb_ready=1. Expect results in order:
  - With CPUCFG_B2B_EN: one every 2 cycles.
  - Without it: one every 3 cycles.
